// File: rtl/ahb_dm_bridge.sv
// AHB-Lite slave front end for the data memory.
// Single word transfers, DM_stall wait states, size/alignment errors and read stall timeout.
module ahb_dm_bridge #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        DM_write,
    output logic        DM_enable,
    output logic [15:0] DM_address,
    output logic [31:0] DM_in,
    input  logic        DM_stall,
    input  logic [31:0] DM_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      state;
    state_t      accept_state;
    logic [15:0] addr_q;
    logic [7:0]  stall_cnt;
    logic        accept;
    logic        legal;
    logic        unused_bits;

    assign unused_bits = ^{HADDR[31:18], HTRANS[0]};

    assign accept = HSEL && HREADY && HTRANS[1];
    assign legal  = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);

    // Where an address phase seen this cycle would take the data phase.
    always_comb begin
        accept_state = S_IDLE;
        if (accept) begin
            if (!legal)
                accept_state = S_ERR1;
            else if (HWRITE)
                accept_state = S_WR;
            else
                accept_state = S_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && HREADYOUT)
                addr_q <= HADDR[17:2];
            unique case (state)
                S_RD: begin
                    if (DM_stall) begin
                        stall_cnt <= stall_cnt + 8'd1;
                        if (stall_cnt == 8'(TIMEOUT - 1))
                            state <= S_ERR1;
                    end else begin
                        state <= accept_state;
                    end
                end
                S_ERR1:  state <= S_ERR2;
                default: state <= accept_state;
            endcase
            // Fresh count for every read data phase, including back-to-back.
            if (HREADYOUT && accept_state == S_RD)
                stall_cnt <= '0;
        end
    end

    assign HREADYOUT  = (state == S_RD) ? ~DM_stall : (state != S_ERR1);
    assign HRESP      = (state == S_ERR1) || (state == S_ERR2);
    assign HRDATA     = (state == S_RD) ? DM_out : '0;
    assign DM_write   = (state == S_WR);
    assign DM_enable  = (state == S_RD);
    assign DM_address = (state == S_WR || state == S_RD) ? addr_q : '0;
    assign DM_in      = (state == S_WR) ? HWDATA : '0;

endmodule

// File: tb/tb_ahb_dm_bridge.sv
// Bench for ahb_dm_bridge: transaction-level bus model, behavioural DM,
// per-cycle comparison of all bridge outputs.
module tb_ahb_dm_bridge;

    localparam int TMO = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        HSEL = 0;
    logic [31:0] HADDR = 0;
    logic [1:0]  HTRANS = 0;
    logic        HWRITE = 0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = 0;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        DM_write;
    logic        DM_enable;
    logic [15:0] DM_address;
    logic [31:0] DM_in;
    logic        DM_stall;
    logic [31:0] DM_out;

    always #5 clk = ~clk;

    assign HREADY = HREADYOUT;

    ahb_dm_bridge #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .HRDATA(HRDATA), .DM_write(DM_write),
        .DM_enable(DM_enable), .DM_address(DM_address),
        .DM_in(DM_in), .DM_stall(DM_stall), .DM_out(DM_out)
    );

    // Behavioural DM: two stall cycles per read, forced stall on demand.
    bit [31:0] dm_mem [0:65535];
    int        dm_cnt;
    logic      force_stall = 0;

    assign DM_stall = DM_enable && (force_stall || dm_cnt < 2);
    assign DM_out   = DM_enable ? dm_mem[DM_address] : 32'h0;

    always @(posedge clk) begin
        if (rst || !DM_enable || !DM_stall)
            dm_cnt <= 0;
        else
            dm_cnt <= dm_cnt + 1;
        if (!rst && DM_write)
            dm_mem[DM_address] <= DM_in;
    end

    // Expected outputs for the current cycle.
    bit        exp_on = 0;
    bit        exp_rdy;
    bit        exp_resp;
    bit        exp_wr;
    bit        exp_en;
    bit [15:0] exp_addr;
    bit [31:0] exp_din;
    int        exp_rdm;
    bit [31:0] exp_rdata;

    int tests = 0;
    int fails = 0;
    int waits = 0;
    int nwr = 0;
    int nen = 0;
    bit [31:0] rd_log [$];
    int        wt_log [$];

    always @(negedge clk) begin
        if (exp_on) begin
            tests++;
            if ({HREADYOUT, HRESP, DM_write, DM_enable, DM_address, DM_in} !==
                {exp_rdy, exp_resp, exp_wr, exp_en, exp_addr, exp_din}) begin
                fails++;
                $display("FAIL ctl t=%0t got rdy%b resp%b wr%b en%b a%h d%h exp rdy%b resp%b wr%b en%b a%h d%h",
                    $time, HREADYOUT, HRESP, DM_write, DM_enable, DM_address, DM_in,
                    exp_rdy, exp_resp, exp_wr, exp_en, exp_addr, exp_din);
            end
            if (exp_rdm != 2) begin
                tests++;
                if (HRDATA !== (exp_rdm == 1 ? exp_rdata : 32'h0)) begin
                    fails++;
                    $display("FAIL hrdata t=%0t got %h exp %h", $time, HRDATA,
                        exp_rdm == 1 ? exp_rdata : 32'h0);
                end
            end
            if (exp_rdm == 1) begin
                rd_log.push_back(HRDATA);
                wt_log.push_back(waits);
            end
        end
        waits = HREADYOUT ? 0 : waits + 1;
        if (DM_write) nwr++;
        if (DM_enable) nen++;
    end

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        write;
        bit [31:0] addr;
        bit [2:0]  size;
        bit [31:0] data;
        bit        stall;
    } xfer_t;

    xfer_t seq [$];
    bit [31:0] ref_mem [int];

    function automatic bit [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_rdy = 1; exp_resp = 0; exp_wr = 0; exp_en = 0;
        exp_addr = 0; exp_din = 0; exp_rdm = 0; exp_rdata = 0;
    endtask

    function automatic xfer_t mk(input bit w, input bit [31:0] a,
                                 input bit [31:0] d);
        xfer_t x;
        x.sel = 1; x.trans = 2'b10; x.write = w; x.addr = a;
        x.size = 3'b010; x.data = d; x.stall = 0;
        return x;
    endfunction

    // Plays the queued transfers as a pipelined AHB master would.
    task automatic run_seq();
        xfer_t cur;
        bit    busy = 0;
        bit    fin;
        bit    legal = 0;
        int    k = 0;
        int    i = 0;
        int    wa = 0;
        while (i < seq.size() || busy) begin
            if (i < seq.size()) begin
                HSEL = seq[i].sel; HTRANS = seq[i].trans;
                HWRITE = seq[i].write; HADDR = seq[i].addr;
                HSIZE = seq[i].size;
            end else begin
                HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HSIZE = 3'b010;
            end
            HWDATA = 0; force_stall = 0;
            exp_idle();
            fin = 1;
            if (busy) begin
                legal = cur.size == 3'b010 && cur.addr[1:0] == 0;
                wa = int'(cur.addr[17:2]);
                if (!legal) begin
                    exp_resp = 1; exp_rdy = (k == 1); fin = (k == 1);
                end else if (cur.write) begin
                    HWDATA = cur.data;
                    exp_wr = 1; exp_addr = 16'(wa); exp_din = cur.data;
                end else if (cur.stall) begin
                    force_stall = 1;
                    if (k < TMO) begin
                        exp_rdy = 0; exp_en = 1; exp_addr = 16'(wa);
                        exp_rdm = 2; fin = 0;
                    end else begin
                        exp_resp = 1; exp_rdy = (k == TMO + 1);
                        fin = (k == TMO + 1);
                    end
                end else begin
                    exp_en = 1; exp_addr = 16'(wa);
                    fin = (k == 2); exp_rdy = fin;
                    exp_rdm = fin ? 1 : 2; exp_rdata = ref_rd(wa);
                end
            end
            exp_on = 1;
            tick();
            if (fin) begin
                if (busy && legal && cur.write)
                    ref_mem[wa] = cur.data;
                busy = 0; k = 0;
                if (i < seq.size()) begin
                    if (seq[i].sel && seq[i].trans[1]) begin
                        cur = seq[i]; busy = 1;
                    end
                    i++;
                end
            end else begin
                k++;
            end
        end
        seq.delete();
    endtask

    task automatic chk(input string name, input bit [31:0] got,
                       input bit [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, want);
        end
    endtask

    xfer_t x;
    int    en_before;

    initial begin
        exp_idle();
        tick();
        exp_on = 1;
        tick();
        rst = 0;
        tick();

        seq.push_back(mk(1, 32'h10, 32'hDEADBEEF));
        seq.push_back(mk(0, 32'h10, 0));
        run_seq();
        chk("ref_pin", ref_rd(4), 32'hDEADBEEF);
        chk("rd_deadbeef", rd_log[0], 32'hDEADBEEF);
        chk("rd_waits", 32'(wt_log[0]), 2);
        chk("nwr_a", 32'(nwr), 1);

        for (int j = 1; j <= 3; j++)
            seq.push_back(mk(1, 32'(4 * j), 32'(j)));
        for (int j = 1; j <= 3; j++)
            seq.push_back(mk(0, 32'(4 * j), 0));
        run_seq();
        for (int j = 1; j <= 3; j++) begin
            chk("rd_b2b", rd_log[j], 32'(j));
            chk("rd_b2b_waits", 32'(wt_log[j]), 2);
        end
        chk("nwr_b", 32'(nwr), 4);

        en_before = nen;
        x = mk(0, 32'h20, 0); x.size = 3'b001;
        seq.push_back(x);
        seq.push_back(mk(1, 32'h22, 32'h55));
        run_seq();
        chk("nwr_err", 32'(nwr), 4);
        chk("nen_err", 32'(nen), 32'(en_before));

        seq.push_back(mk(1, 32'h100, 32'hA5A50100));
        x = mk(0, 32'h100, 0); x.stall = 1;
        seq.push_back(x);
        seq.push_back(mk(0, 32'h100, 0));
        run_seq();
        chk("rd_after_tmo", rd_log[4], 32'hA5A50100);
        chk("nwr_d", 32'(nwr), 5);

        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h200;
        HSIZE = 3'b010; exp_idle();
        tick();
        HSEL = 0; HTRANS = 0; HADDR = 0;
        exp_rdy = 0; exp_en = 1; exp_addr = 16'h80; exp_rdm = 2;
        tick();
        rst = 1;
        tick();
        rst = 0; exp_idle();
        tick();

        en_before = nen;
        x = mk(0, 32'h30, 0); x.trans = 2'b00; seq.push_back(x);
        x = mk(1, 32'h34, 1); x.trans = 2'b01; seq.push_back(x);
        x = mk(1, 32'h38, 2); x.sel = 0; seq.push_back(x);
        x = mk(0, 32'h3C, 0); x.trans = 2'b01; seq.push_back(x);
        run_seq();
        chk("nwr_idle", 32'(nwr), 5);
        chk("nen_idle", 32'(nen), 32'(en_before));
        chk("rd_count", 32'(rd_log.size()), 5);

        exp_on = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_dm_bridge.md
# ahb_dm_bridge

AHB-Lite slave front end for the data memory block. Converts single 32-bit AHB transfers into DM port cycles (DM_write / DM_enable / DM_address / DM_in) and returns DM_out as HRDATA. It also maps DM_stall onto HREADYOUT wait states. It sits between the AHB interconnect (slave select already decoded into HSEL) and the DM, and adds size/alignment checking and a stall timeout.

## Interface
- TIMEOUT, 15: maximum consecutive read stall cycles before an ERROR response (1..255).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address. HADDR[17:2] is the DM word address; HADDR[31:18] is ignored.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  only 3'b010 (word) is legal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (previous transfer completing).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.
- DM_write  out  1  DM write strobe.
- DM_enable  out  1  DM read request.
- DM_address  out  16  DM word address.
- DM_in  out  32  DM write data.
- DM_stall  in  1  DM not ready for the requested read.
- DM_out  in  32  DM read data, valid in the cycle DM_stall is low with DM_enable high.

## Operation
- Accept: HSEL & HREADY & HTRANS[1]. On accept, latch HADDR[17:2], HWRITE, and a legality flag. The flag is HSIZE==3'b010 and HADDR[1:0]==0.
- IDLE or BUSY transfers, and cycles without HSEL, are not accepted. They produce no DM activity and an OKAY response with zero wait states.
- States: IDLE, WR, RD, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0, DM_write=0, DM_enable=0. An accepted legal write goes to WR, a legal read goes to RD, an illegal transfer goes to ERR1.
- WR (one cycle): DM_write=1, DM_enable=0, DM_address=latched address, DM_in=HWDATA (combinational), HREADYOUT=1, HRESP=0.
- RD: DM_enable=1, DM_address=latched address, held constant for the whole data phase. HREADYOUT=~DM_stall, HRDATA=DM_out, HRESP=0.
  - RD exits when DM_stall=0.
  - While in RD, an 8-bit stall counter increments on each DM_stall=1 cycle.
  - If the counter reaches TIMEOUT while DM_stall=1, the next state is ERR1 and DM_enable drops.
- ERR1: HREADYOUT=0, HRESP=1, no DM activity; always goes to ERR2.
- ERR2: HREADYOUT=1, HRESP=1, no DM activity. A new transfer may be accepted here.
- Pipelining: a new address phase may be accepted in any cycle with HREADYOUT=1 (IDLE, WR, RD-final, ERR2). The next state is chosen as from IDLE; otherwise the next state is IDLE.
- The stall counter clears on every entry to RD.
- HRDATA is 0 outside RD.
- DM_in and DM_address are 0 when unused.

## Timing
- Reset (rst=1 at an edge):
  - Next cycle: state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0, DM_write=0, DM_enable=0, DM_address=0, DM_in=0.
  - Reset mid-transfer abandons the transfer with no DM write issued afterwards. The DM shares rst.
- Write latency: zero wait states. The DM array updates at the end of the data-phase cycle.
- Read latency: wait states equal the DM_stall cycles. The DM currently stalls 2 cycles, giving a 3-cycle data phase.
- Read after write to the same address, back to back, returns the new data. The DM re-samples the array every cycle while DM_address is held.
- Back-to-back reads: DM_enable stays 1 across the boundary and DM_address switches in the first cycle of the new RD.
- Error: always exactly two data-phase cycles (ERR1, ERR2), including after a timeout.
- Timeout: the ERROR response starts the cycle after the TIMEOUT-th consecutive stall cycle.
- A transfer presented with HREADY=0 is ignored.

## Test plan
- Reset with rst=1 for 2 cycles -> all outputs at reset values and HREADYOUT=1.
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010:
  - write: one cycle with DM_write=1, DM_address=4, HREADYOUT=1;
  - read: HREADYOUT low for 2 cycles, then HRDATA=0xDEADBEEF with HRESP=0.
- Writes to 0x4, 0x8, 0xC (0x1, 0x2, 0x3) back to back, then pipelined reads of the same addresses:
  - three zero-wait write beats;
  - each read returns its value after 2 wait states, and DM_address switches on the accept edge.
- Halfword read (HSIZE=001) at 0x20, then word write at misaligned 0x22:
  - each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1);
  - DM_write and DM_enable never assert.
- DM_stall forced high with TIMEOUT=4, read 0x100:
  - 4 stall cycles, then ERR1/ERR2 with DM_enable low in ERR1;
  - the next legal read completes normally once DM_stall is released.
- rst asserted in the 2nd wait cycle of a read, plus an IDLE/BUSY HTRANS sequence:
  - reset: state IDLE next cycle, DM_enable=0, no error;
  - IDLE/BUSY: zero-wait OKAY with no DM strobes.
